// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture packer.
package capture_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_FILL,
        CAP_DONE
    } cap_state_t;

    localparam logic [15:0] HEADER_MAGIC = 16'hCA9E;

    // Sign-extend the low 'width' bits of raw to a full 16-bit sample.
    function automatic logic [15:0] sext16(input logic [15:0] raw, input int width);
        logic signed [15:0] t;
        t = $signed(raw << (16 - width));
        return t >>> (16 - width);
    endfunction

endpackage

// File: rtl/capture_decimator.sv
// Keeps one of every (code+1) valid samples; code is latched at arm.
module capture_decimator #(
    parameter int DECIM_WIDTH = 26
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   load,
    input  logic [DECIM_WIDTH-1:0] code,
    input  logic                   run,
    input  logic                   valid,
    output logic                   take
);

    logic [DECIM_WIDTH-1:0] code_q;
    logic [DECIM_WIDTH-1:0] cnt;

    assign take = run && valid && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            code_q <= '0;
            cnt    <= '0;
        end else if (load) begin
            code_q <= code;
            cnt    <= '0;
        end else if (run && valid) begin
            cnt <= take ? code_q : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/capture_packer.sv
// Decimates paired ADC samples, packs two pairs per 64-bit word, streams a capture.
// CAPTURE_HEADER_EN: word 0 of each capture is a header instead of sample data.
module capture_packer
    import capture_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 14,
    parameter int DECIM_WIDTH    = 26,
    parameter int CAPTURE_WORDS  = 2048,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic                      arm_i,
    input  logic [DECIM_WIDTH-1:0]    decimation_code_i,
    input  logic                      sample_valid_i,
    input  logic [ADC_DATA_WIDTH-1:0] sample_a_i,
    input  logic [ADC_DATA_WIDTH-1:0] sample_b_i,
    output logic [63:0]               data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overflow_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPTURE_WORDS - 1);

    cap_state_t state;
    cap_state_t state_next;

    logic                  arm_q;
    logic                  arm_rise;
    logic                  start;
    logic                  accept;
    logic                  room;
    logic                  run;
    logic                  take;
    logic                  half;
    logic                  final_in;
    logic [31:0]           lo;
    logic [15:0]           a16;
    logic [15:0]           b16;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign arm_rise  = arm_i && !arm_q;
    assign start     = arm_rise && (state != CAP_FILL);
    assign accept    = valid_o && ready_i;
    assign room      = !valid_o || ready_i;
    assign run       = (state == CAP_FILL) && !final_in;
    assign a16       = sext16(16'(sample_a_i), ADC_DATA_WIDTH);
    assign b16       = sext16(16'(sample_b_i), ADC_DATA_WIDTH);
    assign next_addr = accept ? cnt + 1'b1 : cnt;
    assign busy_o    = (state == CAP_FILL);
    assign done_o    = (state == CAP_DONE);

    capture_decimator #(
        .DECIM_WIDTH(DECIM_WIDTH)
    ) u_decim (
        .clk  (clk),
        .rst_i(rst_i),
        .load (start),
        .code (decimation_code_i),
        .run  (run),
        .valid(sample_valid_i),
        .take (take)
    );

    // Tracking arm during reset too keeps a held-high arm from looking like an edge.
    always_ff @(posedge clk) begin
        arm_q <= arm_i;
        if (rst_i) begin
            state <= CAP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            CAP_IDLE, CAP_DONE: begin
                if (arm_rise) begin
                    state_next = CAP_FILL;
                end
            end
            CAP_FILL: begin
                if (accept && addr_o == LAST_ADDR) begin
                    state_next = CAP_DONE;
                end
            end
            default: state_next = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            data_o     <= '0;
            valid_o    <= 1'b0;
            addr_o     <= '0;
            overflow_o <= 1'b0;
            cnt        <= '0;
            half       <= 1'b0;
            final_in   <= 1'b0;
            lo         <= '0;
        end else if (start) begin
            cnt        <= '0;
            half       <= 1'b0;
            final_in   <= 1'b0;
            overflow_o <= 1'b0;
            lo         <= '0;
            addr_o     <= '0;
`ifdef CAPTURE_HEADER_EN
            data_o     <= {HEADER_MAGIC, 6'b0, 26'(decimation_code_i),
                           16'(CAPTURE_WORDS - 1)};
            valid_o    <= 1'b1;
`else
            valid_o    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                cnt     <= cnt + 1'b1;
                valid_o <= 1'b0;
            end
            if (take) begin
                half <= !half;
                if (!half) begin
                    lo <= {b16, a16};
                end else if (room) begin
                    data_o   <= {b16, a16, lo};
                    valid_o  <= 1'b1;
                    addr_o   <= next_addr;
                    final_in <= (next_addr == LAST_ADDR);
                end else begin
                    // Output still held: drop the word, address stream stays gap-free.
                    overflow_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_capture_packer.sv
// Directed bench for capture_packer: sign packing table plus multi-cycle sequences.
module tb_capture_packer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        arm_i;
    logic [25:0] decimation_code_i;
    logic        sample_valid_i;
    logic [13:0] sample_a_i;
    logic [13:0] sample_b_i;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] addr_o;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit gen = 1'b0;

    logic [63:0] acc_d[$];
    logic [31:0] acc_a[$];

    typedef struct {
        logic [13:0] a0;
        logic [13:0] b0;
        logic [13:0] a1;
        logic [13:0] b1;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[4];

    capture_packer dut (
        .clk              (clk),
        .rst_i            (rst_i),
        .arm_i            (arm_i),
        .decimation_code_i(decimation_code_i),
        .sample_valid_i   (sample_valid_i),
        .sample_a_i       (sample_a_i),
        .sample_b_i       (sample_b_i),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .addr_o           (addr_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) begin
            acc_d.push_back(data_o);
            acc_a.push_back(addr_o);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        if (gen) begin
            sample_valid_i = 1'b1;
            sample_a_i     = 14'(n);
            sample_b_i     = 14'(-n);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        gen            = 1'b0;
        sample_valid_i = 1'b0;
        rst_i          = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic arm(input logic [25:0] code);
        gen               = 1'b0;
        sample_valid_i    = 1'b0;
        decimation_code_i = code;
        acc_d.delete();
        acc_a.delete();
        arm_i = 1'b0;
        tick();
        arm_i = 1'b1;
        n     = 0;
        tick();
    endtask

    task automatic wait_words(input int k, input int budget, output int t);
        t = 0;
        while (acc_d.size() < k && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (acc_d.size() < k) begin
            errors++;
            $display("FAIL wait_words: got %0d words, required %0d", acc_d.size(), k);
        end
    endtask

    function automatic logic [63:0] model_word(input int s);
        return {16'(-(s + 1)), 16'(s + 1), 16'(-s), 16'(s)};
    endfunction

    initial begin
        int t;
        int bad;

        vecs[0] = '{14'h2000, 14'h1FFF, 14'h0000, 14'h3FFF, 64'hFFFF_0000_1FFF_E000};
        vecs[1] = '{14'h1FFF, 14'h2000, 14'h0001, 14'h3FFE, 64'hFFFE_0001_E000_1FFF};
        vecs[2] = '{14'h0ABC, 14'h3543, 14'h1234, 14'h2EDC, 64'hEEDC_1234_F543_0ABC};
        vecs[3] = '{14'h3FFF, 14'h0001, 14'h2001, 14'h1000, 64'h1000_E001_0001_FFFF};

        rst_i             = 1'b1;
        arm_i             = 1'b1;
        ready_i           = 1'b1;
        decimation_code_i = '0;
        sample_valid_i    = 1'b0;
        sample_a_i        = '0;
        sample_b_i        = '0;

        // arm held high through reset must not start a capture
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (4) tick();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_addr", 64'(addr_o), 64'd0);

`ifdef CAPTURE_HEADER_EN
        do_reset();
        arm(26'd5);
        chk("hdr_valid", 64'(valid_o), 64'd1);
        chk("hdr_data", data_o, 64'hCA9E_0000_0005_07FF);
        chk("hdr_addr", 64'(addr_o), 64'd0);
        gen = 1'b1;
        wait_words(2, 40, t);
        chk("hdr_w1_addr", 64'(acc_a[1]), 64'd1);
        chk("hdr_w1_a0", 64'(acc_d[1][15:0]), 64'd0);
        chk("hdr_w1_a1", 64'(acc_d[1][47:32]), 64'd6);
`else
        // sign-extension and lane placement
        for (int i = 0; i < 4; i++) begin
            do_reset();
            arm(26'd0);
            sample_valid_i = 1'b1;
            sample_a_i     = vecs[i].a0;
            sample_b_i     = vecs[i].b0;
            tick();
            sample_a_i = vecs[i].a1;
            sample_b_i = vecs[i].b1;
            tick();
            sample_valid_i = 1'b0;
            chk($sformatf("vec%0d_valid", i), 64'(valid_o), 64'd1);
            chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), 64'(addr_o), 64'd0);
        end

        // code 3, code input changed after arm must be ignored
        do_reset();
        arm(26'd3);
        decimation_code_i = 26'd0;
        gen = 1'b1;
        wait_words(2, 60, t);
        chk("dec3_w0", acc_d[0], 64'hFFFC_0004_0000_0000);
        chk("dec3_w1", acc_d[1], 64'hFFF4_000C_FFF8_0008);

        // full capture at code 0 with continuous ready
        do_reset();
        arm(26'd0);
        gen = 1'b1;
        wait_words(2048, 5000, t);
        chk("full_cycles", 64'(t), 64'd4097);
        chk("full_count", 64'(acc_d.size()), 64'd2048);
        chk("full_w0", acc_d[0], 64'hFFFF_0001_0000_0000);
        chk("full_last_addr", 64'(acc_a[2047]), 64'd2047);
        bad = 0;
        for (int k = 0; k < acc_d.size(); k++) begin
            if (acc_d[k] !== model_word(2 * k) || acc_a[k] !== 32'(k)) bad++;
        end
        chk("full_stream", 64'(bad), 64'd0);
        chk("full_done", 64'(done_o), 64'd1);
        chk("full_busy", 64'(busy_o), 64'd0);
        chk("full_ovf", 64'(overflow_o), 64'd0);
        repeat (3) tick();
        chk("full_valid_after", 64'(valid_o), 64'd0);
        chk("full_done_held", 64'(done_o), 64'd1);

        // re-arm from DONE, then stall ready for 5 cycles
        arm(26'd0);
        chk("rearm_done", 64'(done_o), 64'd0);
        chk("rearm_busy", 64'(busy_o), 64'd1);
        gen = 1'b1;
        wait_words(4, 40, t);
        ready_i = 1'b0;
        repeat (5) tick();
        chk("stall_ovf", 64'(overflow_o), 64'd1);
        ready_i = 1'b1;
        wait_words(12, 80, t);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (acc_a[k] !== 32'(k)) bad++;
        end
        chk("stall_addrs", 64'(bad), 64'd0);
        chk("stall_drop2", 64'(acc_d[11][15:0]), 64'd26);

        // reset mid-capture, then restart
        do_reset();
        arm(26'd0);
        gen = 1'b1;
        wait_words(101, 400, t);
        chk("mid_addr100", 64'(acc_a[100]), 64'd100);
        gen            = 1'b0;
        sample_valid_i = 1'b0;
        rst_i          = 1'b1;
        tick();
        chk("mid_valid", 64'(valid_o), 64'd0);
        chk("mid_busy", 64'(busy_o), 64'd0);
        chk("mid_addr", 64'(addr_o), 64'd0);
        chk("mid_data", data_o, 64'd0);
        rst_i = 1'b0;
        arm(26'd0);
        gen = 1'b1;
        wait_words(1, 20, t);
        chk("restart_addr", 64'(acc_a[0]), 64'd0);
        chk("restart_w0", acc_d[0], 64'hFFFF_0001_0000_0000);
        chk("restart_ovf", 64'(overflow_o), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
